// File: rtl/lspc_vram_pkg.sv
// rtl/lspc_vram_pkg.sv - register selects, state encoding and address helper for the CPU VRAM port
package lspc_vram_pkg;

    localparam logic [1:0]  REG_VRAMADDR    = 2'd0;
    localparam logic [1:0]  REG_VRAMRW      = 2'd1;
    localparam logic [1:0]  REG_VRAMMOD     = 2'd2;
    localparam logic [15:0] RD_TIMEOUT_FILL = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        INC     = 2'd3
    } vram_state_t;

    // Bit 15 picks fast/slow VRAM and is never carried into.
    function automatic logic [15:0] addr_inc(input logic [15:0] a, input logic [15:0] m);
        return {a[15], a[14:0] + m[14:0]};
    endfunction

endpackage

// File: rtl/vram_wr_queue.sv
// rtl/vram_wr_queue.sv - 2-entry {addr,data} write FIFO, built only with VRAM_WR_QUEUE_EN
`ifdef VRAM_WR_QUEUE_EN
module vram_wr_queue (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] push_addr,
    input  logic [15:0] push_data,
    output logic [15:0] head_addr,
    output logic [15:0] head_data,
    output logic [15:0] next_addr,
    output logic        empty,
    output logic        last
);
    logic [15:0] addr0, data0, addr1, data1;
    logic [1:0]  cnt;
    logic        do_pop;

    assign do_pop    = pop && (cnt != 2'd0);
    assign head_addr = addr0;
    assign head_data = data0;
    assign next_addr = addr1;
    assign empty     = (cnt == 2'd0);
    assign last      = (cnt == 2'd1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr0 <= '0;
            data0 <= '0;
            addr1 <= '0;
            data1 <= '0;
            cnt   <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        addr0 <= push_addr;
                        data0 <= push_data;
                        cnt   <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        addr1 <= push_addr;
                        data1 <= push_data;
                        cnt   <= 2'd2;
                    end else begin
                        // Full: newest entry keeps its address, data is replaced.
                        data1 <= push_data;
                    end
                end
                2'b01: begin
                    addr0 <= addr1;
                    data0 <= data1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        addr0 <= push_addr;
                        data0 <= push_data;
                    end else begin
                        addr0 <= addr1;
                        data0 <= data1;
                        addr1 <= push_addr;
                        data1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`endif

// File: rtl/lspc_vram_cpu_port.sv
// rtl/lspc_vram_cpu_port.sv - CPU side of the VRAM access protocol (VRAMADDR/VRAMRW/VRAMMOD)
// VRAM_WR_QUEUE_EN: buffer VRAMRW writes in a 2-entry FIFO instead of a single data register.
module lspc_vram_cpu_port
    import lspc_vram_pkg::*;
#(
    parameter logic [15:0] MOD_RST    = 16'd1,
    parameter logic [7:0]  RD_TIMEOUT = 8'd255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_WR,
    input  logic        CPU_RD,
    input  logic [1:0]  REG_SEL,
    input  logic [15:0] CPU_DIN,
    output logic [15:0] CPU_DOUT,
    output logic [15:0] VRAM_ADDR,
    output logic [15:0] VRAM_WRITE,
    output logic        REG_VRAMADDR_MSB,
    output logic        nVRAM_WRITE_REQ,
    input  logic        WR_ACK,
    input  logic        RD_STB,
    input  logic [15:0] RD_DATA,
    output logic        BUSY
);
    vram_state_t state, state_nx;
    logic [15:0] vram_addr, vrammod, rd_latch, addr_pend, cpu_dout_q;
    logic [15:0] mod_eff, addr_apply, rd_mux;
    logic [7:0]  rd_timer;
    logic        addr_pend_v, wr_addr, wr_rw, wr_mod, rd_timeout, ack, last_wr, wr_in_inc;

    assign wr_addr    = CPU_WR && (REG_SEL == REG_VRAMADDR);
    assign wr_rw      = CPU_WR && (REG_SEL == REG_VRAMRW);
    assign wr_mod     = CPU_WR && (REG_SEL == REG_VRAMMOD);
    assign mod_eff    = wr_mod ? CPU_DIN : vrammod;
    assign rd_timeout = (rd_timer == RD_TIMEOUT - 8'd1);
    assign ack        = (state == WR_WAIT) && WR_ACK;
    assign addr_apply = wr_addr ? CPU_DIN : addr_pend;

`ifdef VRAM_WR_QUEUE_EN
    logic        q_empty, q_last;
    logic [15:0] q_head_addr, q_head_data, q_next_addr, q_push_addr;

    assign last_wr   = q_last && !wr_rw;
    assign wr_in_inc = wr_rw;

    // Each entry targets the address the write would reach after all earlier queued writes.
    always_comb begin
        q_push_addr = addr_inc(q_last ? q_head_addr : q_next_addr, mod_eff);
        if (q_empty)
            q_push_addr = (state == INC) ? addr_inc(vram_addr, mod_eff) : vram_addr;
    end

    vram_wr_queue u_wr_queue (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (wr_rw),
        .pop       (ack),
        .push_addr (q_push_addr),
        .push_data (CPU_DIN),
        .head_addr (q_head_addr),
        .head_data (q_head_data),
        .next_addr (q_next_addr),
        .empty     (q_empty),
        .last      (q_last)
    );

    assign VRAM_ADDR  = q_empty ? vram_addr : q_head_addr;
    assign VRAM_WRITE = q_head_data;
`else
    logic [15:0] vram_write;

    assign last_wr    = 1'b1;
    assign wr_in_inc  = 1'b0;
    assign VRAM_ADDR  = vram_addr;
    assign VRAM_WRITE = vram_write;

    // A second VRAMRW write before the ack simply replaces the data (lost write).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            vram_write <= '0;
        else if (wr_rw)
            vram_write <= CPU_DIN;
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (wr_rw) state_nx = WR_WAIT;
                     else if (wr_addr) state_nx = RD_WAIT;
            RD_WAIT: if (wr_rw) state_nx = WR_WAIT;
                     else if (!wr_addr && (RD_STB || rd_timeout)) state_nx = IDLE;
            WR_WAIT: if (ack && last_wr) state_nx = (addr_pend_v || wr_addr) ? RD_WAIT : INC;
            INC:     state_nx = wr_in_inc ? WR_WAIT : RD_WAIT;
        endcase
    end

    always_comb begin
        BUSY             = (state != IDLE);
        nVRAM_WRITE_REQ  = (state != WR_WAIT);
        REG_VRAMADDR_MSB = VRAM_ADDR[15];
        CPU_DOUT         = cpu_dout_q;
        case (REG_SEL)
            REG_VRAMADDR: rd_mux = VRAM_ADDR;
            REG_VRAMRW:   rd_mux = rd_latch;
            REG_VRAMMOD:  rd_mux = vrammod;
            default:      rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vram_addr   <= '0;
            vrammod     <= MOD_RST;
            rd_latch    <= '0;
            cpu_dout_q  <= '0;
            addr_pend   <= '0;
            addr_pend_v <= 1'b0;
            rd_timer    <= '0;
        end else begin
            if (wr_mod)
                vrammod <= CPU_DIN;
            if (CPU_RD && !CPU_WR)
                cpu_dout_q <= rd_mux;
            rd_timer <= rd_timer + 8'd1;
            unique case (state)
                IDLE, RD_WAIT: begin
                    if (wr_addr) begin
                        vram_addr <= CPU_DIN;
                        rd_timer  <= '0;
                    end else if (state == RD_WAIT && RD_STB)
                        rd_latch <= RD_DATA;
                    else if (state == RD_WAIT && rd_timeout)
                        rd_latch <= RD_TIMEOUT_FILL;
                end
                // An address write here waits for the in-flight write to finish at the old address.
                WR_WAIT: begin
                    if (ack && last_wr) begin
                        addr_pend_v <= 1'b0;
                        rd_timer    <= '0;
                        vram_addr   <= (addr_pend_v || wr_addr) ? addr_apply : VRAM_ADDR;
                    end else if (wr_addr) begin
                        addr_pend   <= CPU_DIN;
                        addr_pend_v <= 1'b1;
                    end
                end
                INC: begin
                    vram_addr <= wr_addr ? CPU_DIN : addr_inc(vram_addr, mod_eff);
                    rd_timer  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lspc_vram_cpu_port.sv
// tb/tb_lspc_vram_cpu_port.sv - directed/randomized self-checking bench for lspc_vram_cpu_port
module tb_lspc_vram_cpu_port;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CPU_WR = 1'b0;
    logic        CPU_RD = 1'b0;
    logic        WR_ACK = 1'b0;
    logic        RD_STB = 1'b0;
    logic [1:0]  REG_SEL = 2'd0;
    logic [15:0] CPU_DIN = 16'h0000;
    logic [15:0] RD_DATA = 16'h0000;
    logic [15:0] CPU_DOUT, VRAM_ADDR, VRAM_WRITE;
    logic        REG_VRAMADDR_MSB, nVRAM_WRITE_REQ, BUSY;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_addr, m_mod, m_data;

    always #5 CLK = ~CLK;

    lspc_vram_cpu_port dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .CPU_WR           (CPU_WR),
        .CPU_RD           (CPU_RD),
        .REG_SEL          (REG_SEL),
        .CPU_DIN          (CPU_DIN),
        .CPU_DOUT         (CPU_DOUT),
        .VRAM_ADDR        (VRAM_ADDR),
        .VRAM_WRITE       (VRAM_WRITE),
        .REG_VRAMADDR_MSB (REG_VRAMADDR_MSB),
        .nVRAM_WRITE_REQ  (nVRAM_WRITE_REQ),
        .WR_ACK           (WR_ACK),
        .RD_STB           (RD_STB),
        .RD_DATA          (RD_DATA),
        .BUSY             (BUSY)
    );

    // Next address: low 15 bits advance modulo 32768, the region bit is kept.
    function automatic logic [15:0] model_inc(input logic [15:0] a, input logic [15:0] m);
        int unsigned s;
        s = (int'(a) % 32768) + (int'(m) % 32768);
        return (a & 16'h8000) | 16'(s % 32768);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] sel, input logic [15:0] d);
        REG_SEL = sel;
        CPU_DIN = d;
        CPU_WR  = 1'b1;
        @(negedge CLK);
        CPU_WR  = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] sel, output logic [15:0] d);
        REG_SEL = sel;
        CPU_RD  = 1'b1;
        @(negedge CLK);
        CPU_RD  = 1'b0;
        d = CPU_DOUT;
    endtask

    task automatic pulse_rd(input logic [15:0] d);
        RD_DATA = d;
        RD_STB  = 1'b1;
        @(negedge CLK);
        RD_STB  = 1'b0;
    endtask

    task automatic pulse_ack();
        WR_ACK = 1'b1;
        @(negedge CLK);
        WR_ACK = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        int          dly;
        int          low_cnt;

        @(negedge CLK);
        @(negedge CLK);
        chk("reset_req", 16'(nVRAM_WRITE_REQ), 16'd1);
        chk("reset_busy", 16'(BUSY), 16'd0);
        chk("reset_addr", VRAM_ADDR, 16'h0000);
        chk("reset_wdata", VRAM_WRITE, 16'h0000);
        chk("reset_dout", CPU_DOUT, 16'h0000);
        RESET = 1'b0;
        @(negedge CLK);
        cpu_read(2'd2, rd);
        chk("mod_reset_value", rd, 16'h0001);
        cpu_read(2'd1, rd);
        chk("latch_reset_value", rd, 16'h0000);

        // Address write followed by prefetch read data
        for (int i = 0; i < 5; i++) begin
            m_addr = (i == 0) ? 16'h8010 : 16'($urandom);
            m_data = (i == 0) ? 16'h1234 : 16'($urandom);
            dly    = (i == 0) ? 2 : int'($urandom_range(0, 20));
            cpu_write(2'd0, m_addr);
            chk("rd_busy", 16'(BUSY), 16'd1);
            repeat (dly) @(negedge CLK);
            chk("rd_still_busy", 16'(BUSY), 16'd1);
            pulse_rd(m_data);
            chk("rd_idle", 16'(BUSY), 16'd0);
            chk("rd_msb", 16'(REG_VRAMADDR_MSB), 16'(m_addr[15]));
            cpu_read(2'd1, rd);
            chk("rd_latch", rd, m_data);
            cpu_read(2'd0, rd);
            chk("rd_addr_reg", rd, m_addr);
        end

        // Read timeout
        cpu_write(2'd0, 16'($urandom));
        repeat (254) @(negedge CLK);
        chk("timeout_busy_before", 16'(BUSY), 16'd1);
        @(negedge CLK);
        chk("timeout_idle", 16'(BUSY), 16'd0);
        cpu_read(2'd1, rd);
        chk("timeout_fill", rd, 16'hFFFF);

        // Ack with no request outstanding
        m_addr = VRAM_ADDR;
        pulse_ack();
        chk("stray_ack_req", 16'(nVRAM_WRITE_REQ), 16'd1);
        chk("stray_ack_busy", 16'(BUSY), 16'd0);
        chk("stray_ack_addr", VRAM_ADDR, m_addr);

        // Write, ack, increment
        for (int i = 0; i < 6; i++) begin
            m_mod  = (i == 0) ? 16'h0020 : (i == 1) ? 16'h0001 : 16'($urandom);
            m_addr = (i == 0) ? 16'h7FF0 : (i == 1) ? 16'hFFFF : 16'($urandom);
            m_data = (i == 0) ? 16'hBEEF : 16'($urandom);
            dly    = (i == 0) ? 5 : int'($urandom_range(1, 8));
            cpu_write(2'd2, m_mod);
            cpu_write(2'd0, m_addr);
            cpu_write(2'd1, m_data);
            low_cnt = 0;
            repeat (dly) begin
                if (nVRAM_WRITE_REQ === 1'b0) low_cnt++;
                @(negedge CLK);
            end
            chk("wr_req_low_cycles", 16'(low_cnt), 16'(dly));
            chk("wr_data", VRAM_WRITE, m_data);
            chk("wr_addr_hold", VRAM_ADDR, m_addr);
            pulse_ack();
            chk("wr_req_release", 16'(nVRAM_WRITE_REQ), 16'd1);
            chk("wr_inc_busy", 16'(BUSY), 16'd1);
            @(negedge CLK);
            m_addr = model_inc(m_addr, m_mod);
            chk("inc_addr", VRAM_ADDR, m_addr);
            pulse_rd(16'h0000);
            chk("wr_done_idle", 16'(BUSY), 16'd0);
        end

        // Two VRAMRW writes before the first ack
        m_mod  = 16'($urandom_range(1, 16'h7FFF));
        m_addr = 16'($urandom);
        cpu_write(2'd2, m_mod);
        cpu_write(2'd0, m_addr);
        cpu_write(2'd1, 16'h0001);
        cpu_write(2'd1, 16'h0002);
        repeat (2) @(negedge CLK);
`ifdef VRAM_WR_QUEUE_EN
        chk("b2b_q_addr0", VRAM_ADDR, m_addr);
        chk("b2b_q_data0", VRAM_WRITE, 16'h0001);
        pulse_ack();
        chk("b2b_q_req_held", 16'(nVRAM_WRITE_REQ), 16'd0);
        chk("b2b_q_addr1", VRAM_ADDR, model_inc(m_addr, m_mod));
        chk("b2b_q_data1", VRAM_WRITE, 16'h0002);
        pulse_ack();
        chk("b2b_q_req_release", 16'(nVRAM_WRITE_REQ), 16'd1);
        @(negedge CLK);
        chk("b2b_q_final_addr", VRAM_ADDR, model_inc(model_inc(m_addr, m_mod), m_mod));
`else
        chk("b2b_addr", VRAM_ADDR, m_addr);
        chk("b2b_data", VRAM_WRITE, 16'h0002);
        pulse_ack();
        chk("b2b_req_release", 16'(nVRAM_WRITE_REQ), 16'd1);
        @(negedge CLK);
        chk("b2b_single_inc", VRAM_ADDR, model_inc(m_addr, m_mod));
        low_cnt = 0;
        repeat (4) begin
            if (nVRAM_WRITE_REQ === 1'b0) low_cnt++;
            @(negedge CLK);
        end
        chk("b2b_no_second_req", 16'(low_cnt), 16'd0);
`endif
        pulse_rd(16'h0000);

        // Reset in the middle of a write
        cpu_write(2'd2, 16'h0005);
        cpu_read(2'd2, rd);
        chk("mod_readback", rd, 16'h0005);
        cpu_write(2'd1, 16'($urandom));
        chk("rst_pre_req", 16'(nVRAM_WRITE_REQ), 16'd0);
        #2 RESET = 1'b1;
        #1;
        chk("rst_async_req", 16'(nVRAM_WRITE_REQ), 16'd1);
        chk("rst_busy", 16'(BUSY), 16'd0);
        chk("rst_addr", VRAM_ADDR, 16'h0000);
        chk("rst_wdata", VRAM_WRITE, 16'h0000);
        chk("rst_dout", CPU_DOUT, 16'h0000);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        cpu_read(2'd2, rd);
        chk("rst_mod", rd, 16'h0001);

        // Reserved register select has no effect
        cpu_write(2'd3, 16'hFFFF);
        chk("reserved_busy", 16'(BUSY), 16'd0);
        chk("reserved_addr", VRAM_ADDR, 16'h0000);
        cpu_read(2'd2, rd);
        chk("reserved_mod", rd, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
